// File: rtl/onoc_pkg.sv
// Shared types and constants for the optical token-ring transmit path.
// Holds the transmit FSM state encoding and the default flit width.
package onoc_pkg;

  localparam int ONOC_FLIT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    REL  = 2'd2
  } tx_state_e;

  typedef logic [ONOC_FLIT_W-1:0] flit_t;

endpackage

// File: rtl/onoc_sync_fifo.sv
// Purpose : single-clock FIFO buffering ingress flits for the token-ring transmitter.
// Latency : a pushed flit is visible at head the cycle after the push.
// Backpr. : full/empty are registered; push while full and pop while empty are ignored.
// Ports   : clk, rst (async, active-high); push/push_data write side;
//           pop/head read side (head valid when !empty); count/full/empty status.
module onoc_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Storage needs no reset: head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/onoc_token_tx_node.sv
// Purpose : per-node transmitter; buffers local flits, sends bursts while holding the ring token.
// Latency : grant at t -> first tx_valid at t+1; done at t+1+k (k flits, 0..MAX_BURST).
// Backpr. : in_ready low while the FIFO is full (even with a same-cycle pop); channel never stalls.
// Ports   : clk, rst (async, active-high); in_valid/in_ready/in_data ingress;
//           grant in, request/done out to the arbiter; tx_valid/tx_data channel;
//           count occupancy, flits_sent wrapping counter, err sticky grant-loss flag.
module onoc_token_tx_node
  import onoc_pkg::*;
#(
  parameter int DATA_W     = ONOC_FLIT_W,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          grant,
  output logic                          request,
  output logic                          done,
  output logic                          tx_valid,
  output logic [DATA_W-1:0]             tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [15:0]                   flits_sent,
  output logic                          err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] ONE_FLIT  = CW'(1);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [BW-1:0]     burst_cnt;
  logic              push;
  logic              pop;
  logic              grant_lost;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;

  // in_ready comes from the registered count, so a pop in the same cycle
  // does not open a slot until the following cycle.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign request  = !fifo_empty;
  assign tx_data  = tx_valid ? head : '0;

  onoc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    tx_valid   = 1'b0;
    done       = 1'b0;
    grant_lost = 1'b0;
    case (state)
      // Decision uses the registered count; a push arriving with grant is not seen yet.
      IDLE: begin
        if (grant) state_nxt = fifo_empty ? REL : TX;
      end
      TX: begin
        if (!grant) begin
          state_nxt  = IDLE;
          grant_lost = 1'b1;
        end else begin
          tx_valid = 1'b1;
          pop      = 1'b1;
          // Release on burst limit, or when this pop drains the FIFO with nothing arriving.
          if (burst_cnt == LAST_BEAT || (count == ONE_FLIT && !push))
            state_nxt = REL;
        end
      end
      REL: begin
        state_nxt = IDLE;
        if (grant) done       = 1'b1;
        else       grant_lost = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      flits_sent <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        burst_cnt <= '0;
      else if (pop)
        burst_cnt <= burst_cnt + 1'b1;
      if (pop)
        flits_sent <= flits_sent + 16'd1;
      if (grant_lost)
        err <= 1'b1;
    end
  end

endmodule

// File: doc/onoc_token_tx_node.md
Name: onoc_token_tx_node

Overview:
Per-node transmit controller that sits directly upstream of the token-passing arbiter. It drives one bit of that arbiter's request/done vectors and consumes one bit of its grant. It buffers flits from the local electrical side and transmits them onto the shared optical channel only while it holds the token. It releases the token after a bounded burst, or immediately if it has nothing to send, so an idle node never stalls the ring.

Parameters:
DATA_W, 32, flit width in bits
FIFO_DEPTH, 8, ingress buffer depth in flits; power of two, minimum 2
MAX_BURST, 4, maximum flits sent per token hold; minimum 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ingress flit valid
in_ready  out  1  ingress can accept; high when count < FIFO_DEPTH
in_data  in  DATA_W  ingress flit
grant  in  1  this node holds the token (arbiter grant bit)
request  out  1  high when count != 0
done  out  1  one-cycle token release pulse (to the arbiter done bit)
tx_valid  out  1  flit on channel this cycle
tx_data  out  DATA_W  channel flit; equals the FIFO head while tx_valid=1
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
flits_sent  out  16  wrapping count of transmitted flits
err  out  1  sticky protocol error (grant lost while holding)

Behaviour:
- Reset: async clear. state=IDLE, FIFO empty, count=0, burst_cnt=0, flits_sent=0, err=0.
  - Outputs during reset: in_ready=1, request=0, done=0, tx_valid=0, tx_data=0.
  - Reset mid-burst discards all buffered flits. No done is issued.
- Ingress: push when in_valid && in_ready. While full, in_ready=0 even if a pop occurs in the same cycle.
- States: IDLE, TX, REL.
- IDLE:
  - grant=1 && count!=0 -> TX, burst_cnt=0.
  - grant=1 && count==0 -> REL.
  - grant=0 -> stay.
  - A push in the same cycle as grant is not visible to this decision; the decision uses the registered count.
- TX:
  - tx_valid=1 and tx_data=head, combinational from state and FIFO. Pop every cycle. flits_sent+=1. burst_cnt+=1.
  - Go to REL when burst_cnt==MAX_BURST-1, or when count==1 with no push this cycle (FIFO becomes empty).
  - Otherwise stay in TX.
- REL: done=1 for exactly this cycle, then -> IDLE. The arbiter advances its token on this edge, so grant falls the next cycle.
- Latency:
  - Grant seen at cycle t (IDLE) -> first tx_valid at t+1.
  - done at t+1+k, where k = flits sent (0..MAX_BURST).
  - Empty node holds the token for 2 cycles.
- Single-node ring (N=1): grant stays high after done. The node re-enters from IDLE next cycle; this is legal.
- Grant loss in TX or REL (grant=0):
  - Abort immediately, no pop and no done that cycle.
  - -> IDLE, err<=1. err stays set until rst.
- tx_data when tx_valid=0: drive 0.
- flits_sent wraps 0xFFFF -> 0x0000.
- count arithmetic: count_next = count + push - pop. It is never negative because pop occurs only in TX and TX requires count>=1.

Decomposition:
- Package onoc_pkg:
  - enum tx_state_e {IDLE, TX, REL}.
  - Constant ONOC_FLIT_W=32, used as the DATA_W default.
  - Typedef flit_t.
- Sub-module onoc_sync_fifo (parameters DATA_W, DEPTH):
  - Signals: push/pop, head, count, full, empty.
  - Pointers wrap modulo DEPTH.
- The FSM, burst counter, flits_sent and err live in the top module.

Test Plan:
1. Push 3 flits (0xA,0xB,0xC), then grant=1 at t -> tx_valid t+1..t+3 with data A,B,C; done pulse at t+4; count=0; flits_sent=3.
2. Push 6 flits, MAX_BURST=4, grant held -> 4 flits sent, then done; node returns to IDLE with count=2 and request=1. Re-grant -> remaining 2 flits, then done.
3. Empty FIFO, grant=1 at t -> no tx_valid; done=1 only at t+1; request=0 throughout.
4. Fill to 8 flits -> in_ready=0; in_valid held high during the first TX cycle -> no push that cycle; in_ready rises the cycle after the pop.
5. count=1 in TX with a simultaneous push -> node stays in TX, sends the second flit, then REL.
6. Assert rst mid-TX after 2 of 4 flits -> outputs return to reset values immediately. After release, grant=1 gives the empty-node release (done at t+1); flits_sent=0.
7. Drop grant in TX -> tx_valid falls the same cycle; err=1 and stays set; no done pulse.
8. Integration: 4 nodes with the arbiter and mixed loads -> token visits 0,1,2,3 in order; no two tx_valid ever high together.
